pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the single-cycle MIPS-32 datapath. It holds the architectural PC and each cycle selects the next PC: sequential (PC+4), taken branch (PC+4 + sign-extended offset × 4), or jump (region-relative 26-bit index). It is the consumer of the branch-target addition path and sits between control/decode (branch and jump requests, stall) and the instruction memory address port. Redirects that arrive during a stall are buffered in a one-entry pending register.

## Interface
- WIDTH, 32, PC and offset width in bits (fixed at 32 for MIPS-32 jump formation)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_stall  input  1  hold PC this cycle
- i_branch  input  1  taken-branch request, qualified by decode
- i_branch_off  input  WIDTH  sign-extended 16-bit word offset (not yet shifted)
- i_jump  input  1  jump request (J/JAL)
- i_jump_idx  input  26  instruction index field
- o_pc  output  WIDTH  current fetch PC
- o_pc_plus4  output  WIDTH  o_pc + 4, combinational from o_pc
- o_valid  output  1  o_pc is a valid fetch address
- o_redirect  output  1  one-cycle pulse: o_pc was loaded from a branch/jump target this cycle

## Operation
- Clocking: one clock; reset is asynchronous and active-low.
- Targets, computed from the current o_pc, all modulo 2^32:
  - seq = o_pc + 4
  - br = seq + (i_branch_off << 2), with the shift discarding the top two bits
  - jmp = {seq[31:28], i_jump_idx, 2'b00}
- Priority: i_jump over i_branch. Both asserted -> jump target; the branch is dropped.
- Target low two bits are always 0 by construction. No misalignment check.
- FSM states:
  - BOOT: entered on reset.
  - RUN
  - PEND: a redirect target is held in the pending register.
- BOOT -> RUN on the first clock after reset release. o_valid = 0 in BOOT and o_pc is held at RESET_PC. Requests seen in BOOT are ignored.
- RUN, !i_stall:
  - Jump/branch -> o_pc <= target, o_redirect <= 1.
  - Otherwise o_pc <= seq, o_redirect <= 0.
- RUN, i_stall:
  - o_pc held, o_redirect <= 0.
  - A jump/branch captures its target (computed from the held o_pc) into the pending register, and the state goes to PEND.
- PEND, i_stall: o_pc held. New requests are ignored; the first captured redirect wins, since it belongs to the older instruction.
- PEND, !i_stall: o_pc <= pending target, o_redirect <= 1, state -> RUN. A jump/branch asserted in the same cycle is ignored.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, with no flag.
- Reset mid-operation: immediate return to BOOT.
  - o_pc = RESET_PC, o_valid = 0, o_redirect = 0, pending register cleared.

## Timing
- Reset values: o_pc = RESET_PC, o_pc_plus4 = RESET_PC + 4, o_valid = 0, o_redirect = 0, state BOOT, pending = 0.
- o_valid rises on the first rising edge after i_rst_n deasserts and then stays 1 until the next reset.
- Next-PC latency: 1 cycle. A request sampled at edge N gives the target on o_pc after edge N.
- o_redirect is registered and is high for exactly the one cycle the new target is on o_pc.
- Stalled redirect: the target appears on o_pc one cycle after the first sampled cycle with i_stall = 0.
- All outputs except o_pc_plus4 are direct register outputs. There is no combinational path from any input to any output.

## Test plan
- Reset/boot:
  - Stimulus: RESET_PC = 32'h0040_0000, release i_rst_n, no requests.
  - Required: o_valid = 0 and o_pc = 0040_0000 for 1 cycle, then o_pc steps 0040_0004, 0040_0008, 0040_000C with o_valid = 1.
- Branch:
  - Backward: o_pc = 0040_0010 with i_branch = 1, i_branch_off = 32'hFFFF_FFFC (−4) -> next o_pc = 0040_0004, o_redirect = 1 for one cycle.
  - Forward: i_branch_off = 3 from 0040_0010 -> next o_pc = 0040_0020.
- Jump and priority:
  - o_pc = 1000_0000 with i_jump = 1, i_jump_idx = 26'h000_0040 -> next o_pc = 1000_0100.
  - Same stimulus with i_branch = 1 also asserted -> result unchanged (jump wins).
- Stalled redirect:
  - At o_pc = 0040_0008, assert i_stall for 3 cycles and pulse i_branch (offset 4) in stall cycle 1 -> pending target 0040_001C.
  - A second branch in stall cycle 2 (offset 100) is ignored.
  - o_pc holds 0040_0008 throughout the stall, then becomes 0040_001C with o_redirect = 1 one cycle after release.
- Wrap-around: force o_pc to FFFF_FFFC and run sequentially -> o_pc = 0000_0000, then 0000_0004.
- Reset mid-operation: assert i_rst_n = 0 asynchronously while in PEND.
  - Required: o_pc = RESET_PC and o_valid = 0 immediately, with no clock edge needed.
  - After release, the pending target is never applied.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between decode/control and the PC sequencer.
// The slave side is the sequencer; the master side drives requests and observes the PC.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_stall;
    logic             i_branch;
    logic [WIDTH-1:0] i_branch_off;
    logic             i_jump;
    logic [25:0]      i_jump_idx;
    logic [WIDTH-1:0] o_pc;
    logic [WIDTH-1:0] o_pc_plus4;
    logic             o_valid;
    logic             o_redirect;

    modport slave (
        input  i_stall, i_branch, i_branch_off, i_jump, i_jump_idx,
        output o_pc, o_pc_plus4, o_valid, o_redirect
    );

    modport master (
        output i_stall, i_branch, i_branch_off, i_jump, i_jump_idx,
        input  o_pc, o_pc_plus4, o_valid, o_redirect
    );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS-32 program-counter sequencer: sequential, branch and jump next-PC selection,
// with a one-entry pending register holding a redirect that arrives during a stall.
module pc_sequencer #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             redirect_q, redirect_d;

    logic [WIDTH-1:0] seq_tgt;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] req_tgt;
    logic             req;

    always_comb begin
        seq_tgt = pc_q + WIDTH'(4);
        br_tgt  = seq_tgt + {bus.i_branch_off[WIDTH-3:0], 2'b00};
        jmp_tgt = {seq_tgt[WIDTH-1:WIDTH-4], bus.i_jump_idx, 2'b00};
        req     = bus.i_jump | bus.i_branch;
        // Jump has priority; a simultaneous branch is dropped.
        req_tgt = bus.i_jump ? jmp_tgt : br_tgt;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        redirect_d = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                if (!bus.i_stall) begin
                    pc_d       = req ? req_tgt : seq_tgt;
                    redirect_d = req;
                end else if (req) begin
                    pend_d  = req_tgt;
                    state_d = PEND;
                end
            end
            PEND: begin
                // The captured redirect belongs to the older instruction, so later requests are dropped.
                if (!bus.i_stall) begin
                    pc_d       = pend_q;
                    pend_d     = '0;
                    redirect_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.o_pc       = pc_q;
    assign bus.o_pc_plus4 = pc_q + WIDTH'(4);
    assign bus.o_valid    = valid_q;
    assign bus.o_redirect = redirect_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_PC = 32'h0040_0000.
module tb_pc_sequencer;
    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   errors;

    pc_sequencer_if #(.WIDTH(32)) bus ();

    pc_sequencer #(
        .WIDTH    (32),
        .RESET_PC (32'h0040_0000)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic stall, input logic br, input logic [31:0] off,
                           input logic jmp, input logic [25:0] idx);
        bus.i_stall      = stall;
        bus.i_branch     = br;
        bus.i_branch_off = off;
        bus.i_jump       = jmp;
        bus.i_jump_idx   = idx;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst_n = 1'b0;
        idle();
        #12;
        check("rst_pc", bus.o_pc, 32'h0040_0000);
        check("rst_pc_plus4", bus.o_pc_plus4, 32'h0040_0004);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_redirect", 32'(bus.o_redirect), 32'd0);

        // Boot: a request presented during BOOT must be ignored.
        i_rst_n = 1'b1;
        set_req(1'b0, 1'b1, 32'h0000_0010, 1'b0, 26'h0);
        #1;
        check("boot_valid_low", 32'(bus.o_valid), 32'd0);
        tick();
        idle();
        check("boot_pc_held", bus.o_pc, 32'h0040_0000);
        check("boot_valid_high", 32'(bus.o_valid), 32'd1);
        check("boot_no_redirect", 32'(bus.o_redirect), 32'd0);
        tick(); check("seq_4", bus.o_pc, 32'h0040_0004);
        tick(); check("seq_8", bus.o_pc, 32'h0040_0008);
        tick(); check("seq_c", bus.o_pc, 32'h0040_000C);
        check("seq_valid", 32'(bus.o_valid), 32'd1);
        tick(); check("seq_10", bus.o_pc, 32'h0040_0010);

        // Backward branch (-4) from 0040_0010.
        set_req(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
        tick(); idle();
        check("br_back_pc", bus.o_pc, 32'h0040_0004);
        check("br_back_redirect", 32'(bus.o_redirect), 32'd1);
        tick();
        check("br_back_after", bus.o_pc, 32'h0040_0008);
        check("br_back_pulse_end", 32'(bus.o_redirect), 32'd0);
        tick(); tick();
        check("pre_fwd_pc", bus.o_pc, 32'h0040_0010);

        // Forward branch (+3 words).
        set_req(1'b0, 1'b1, 32'h0000_0003, 1'b0, 26'h0);
        tick(); idle();
        check("br_fwd_pc", bus.o_pc, 32'h0040_0020);
        check("br_fwd_redirect", 32'(bus.o_redirect), 32'd1);

        // Back to 0040_0008 (offset -7 from seq 0040_0024).
        set_req(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b0, 26'h0);
        tick(); idle();
        check("pre_stall_pc", bus.o_pc, 32'h0040_0008);

        // Stalled redirect: first branch (offset 4) wins over the second (offset 100).
        set_req(1'b1, 1'b1, 32'h0000_0004, 1'b0, 26'h0);
        tick();
        check("stall1_pc", bus.o_pc, 32'h0040_0008);
        check("stall1_redirect", 32'(bus.o_redirect), 32'd0);
        set_req(1'b1, 1'b1, 32'd100, 1'b0, 26'h0);
        tick();
        check("stall2_pc", bus.o_pc, 32'h0040_0008);
        set_req(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        tick();
        check("stall3_pc", bus.o_pc, 32'h0040_0008);
        // Release with a jump asserted: the pending branch must take effect instead.
        set_req(1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100);
        tick(); idle();
        check("pend_release_pc", bus.o_pc, 32'h0040_001C);
        check("pend_release_redirect", 32'(bus.o_redirect), 32'd1);
        tick();
        check("pend_after_pc", bus.o_pc, 32'h0040_0020);
        check("pend_after_redirect", 32'(bus.o_redirect), 32'd0);

        // Reach 1000_0000 from seq 0040_0024 (offset 03EF_FFF7 words).
        set_req(1'b0, 1'b1, 32'h03EF_FFF7, 1'b0, 26'h0);
        tick(); idle();
        check("to_region1_pc", bus.o_pc, 32'h1000_0000);
        set_req(1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0040);
        tick(); idle();
        check("jump_pc", bus.o_pc, 32'h1000_0100);
        check("jump_redirect", 32'(bus.o_redirect), 32'd1);

        // Back to 1000_0000 (offset -0x41 from seq 1000_0104), then jump+branch.
        set_req(1'b0, 1'b1, 32'hFFFF_FFBF, 1'b0, 26'h0);
        tick(); idle();
        check("back_region1_pc", bus.o_pc, 32'h1000_0000);
        set_req(1'b0, 1'b1, 32'h0000_0005, 1'b1, 26'h000_0040);
        tick(); idle();
        check("jump_prio_pc", bus.o_pc, 32'h1000_0100);
        check("jump_prio_redirect", 32'(bus.o_redirect), 32'd1);

        // Wrap: branch to FFFF_FFFC from seq 1000_0104 (offset 3BFF_FFBE, top bits shifted out).
        set_req(1'b0, 1'b1, 32'h3BFF_FFBE, 1'b0, 26'h0);
        tick(); idle();
        check("wrap_top_pc", bus.o_pc, 32'hFFFF_FFFC);
        check("wrap_top_plus4", bus.o_pc_plus4, 32'h0000_0000);
        tick(); check("wrap_zero", bus.o_pc, 32'h0000_0000);
        tick(); check("wrap_four", bus.o_pc, 32'h0000_0004);

        // Asynchronous reset while PEND holds target 0000_0030.
        set_req(1'b1, 1'b1, 32'h0000_000A, 1'b0, 26'h0);
        tick();
        check("pend_hold_pc", bus.o_pc, 32'h0000_0004);
        idle();
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.o_pc, 32'h0040_0000);
        check("async_rst_valid", 32'(bus.o_valid), 32'd0);
        check("async_rst_redirect", 32'(bus.o_redirect), 32'd0);
        #3 i_rst_n = 1'b1;
        tick();
        check("rerun_boot_pc", bus.o_pc, 32'h0040_0000);
        check("rerun_valid", 32'(bus.o_valid), 32'd1);
        tick();
        check("rerun_seq_pc", bus.o_pc, 32'h0040_0004);
        check("rerun_no_redirect", 32'(bus.o_redirect), 32'd0);
        tick();
        check("rerun_seq2_pc", bus.o_pc, 32'h0040_0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
